// File: rtl/result_bcd_pkg.sv
// Shared sizing and FSM state type for the result-to-BCD converter.
package result_bcd_pkg;
    localparam int DATA_W         = 20;
    localparam int BCD_DIGITS     = 6;
    localparam int SCRATCH_DIGITS = 7;
    localparam int ITERATIONS     = 20;
    localparam int BCD_W          = 4 * BCD_DIGITS;
    localparam int SCRATCH_W      = 4 * SCRATCH_DIGITS;
    localparam int CNT_W          = $clog2(ITERATIONS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;
endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
module bcd_add3 (
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);
    assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

// File: rtl/result_bcd_converter.sv
// Sequential double-dabble converter from a 20-bit ALU result to six BCD digits.
// Define NEG_DISPLAY_EN to treat the input as two's complement and report the sign.
module result_bcd_converter
    import result_bcd_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BCD_W-1:0]     bcd,
    output logic                 overflow,
    output logic                 negative
);
    state_e                 state_q, state_d;
    logic [SCRATCH_W-1:0]   scr_q, scr_d, scr_adj, scr_sh;
    logic [DATA_W-1:0]      opnd_q, opnd_d, opnd_sh, in_mag;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BCD_W-1:0]       bcd_q, bcd_d;
    logic                   ovf_q, ovf_d, neg_q, neg_d, sign_q, sign_d, in_neg;
    logic                   last_iter;

    for (genvar g = 0; g < SCRATCH_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (.d_i(scr_q[4*g +: 4]), .d_o(scr_adj[4*g +: 4]));
    end

`ifdef NEG_DISPLAY_EN
    assign in_neg = in_data[DATA_W-1];
    assign in_mag = in_neg ? -in_data : in_data;
`else
    assign in_neg = 1'b0;
    assign in_mag = in_data;
`endif

    assign {scr_sh, opnd_sh} = {scr_adj[SCRATCH_W-2:0], opnd_q, 1'b0};
    assign last_iter         = (cnt_q == CNT_W'(ITERATIONS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = SHIFT;
            SHIFT:   if (last_iter) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Result registers only move on DONE entry so the display holds the last value.
    always_comb begin
        scr_d  = scr_q;
        opnd_d = opnd_q;
        cnt_d  = cnt_q;
        sign_d = sign_q;
        bcd_d  = bcd_q;
        ovf_d  = ovf_q;
        neg_d  = neg_q;
        if (state_q == IDLE && in_valid) begin
            opnd_d = in_mag;
            sign_d = in_neg;
            scr_d  = '0;
            cnt_d  = '0;
        end else if (state_q == SHIFT) begin
            scr_d  = scr_sh;
            opnd_d = opnd_sh;
            cnt_d  = cnt_q + 1'b1;
            if (last_iter) begin
                neg_d = sign_q;
                if (scr_sh[SCRATCH_W-1 -: 4] == 4'd0) begin
                    bcd_d = scr_sh[BCD_W-1:0];
                    ovf_d = 1'b0;
                end else begin
                    bcd_d = {BCD_DIGITS{4'h9}};
                    ovf_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scr_q  <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
            sign_q <= 1'b0;
            bcd_q  <= '0;
            ovf_q  <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            scr_q  <= scr_d;
            opnd_q <= opnd_d;
            cnt_q  <= cnt_d;
            sign_q <= sign_d;
            bcd_q  <= bcd_d;
            ovf_q  <= ovf_d;
            neg_q  <= neg_d;
        end
    end

    assign bcd      = bcd_q;
    assign overflow = ovf_q;
    assign negative = neg_q;
endmodule

// File: doc/result_bcd_converter.md
RESULT_BCD_CONVERTER -- requirements
Module: result_bcd_converter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port in_valid, input, 1 bit: in_data holds a valid 20-bit ALU result.
REQ-004 SHALL have port in_ready, output, 1 bit: block accepts a new operand this cycle.
REQ-005 SHALL have port in_data, input, 20 bits: binary ALU result to convert.
REQ-006 SHALL have port out_valid, output, 1 bit: bcd, overflow and negative are valid.
REQ-007 SHALL have port out_ready, input, 1 bit: consumer (7-segment driver) takes the result.
REQ-008 SHALL have port bcd, output, 24 bits: six BCD digits, [23:20] most significant, [3:0] least significant.
REQ-009 SHALL have port overflow, output, 1 bit: converted magnitude exceeds 999999.
REQ-010 SHALL have port negative, output, 1 bit: input was interpreted as a negative value.

Function
REQ-011 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-012 SHALL drive in_ready=1 only in IDLE, with no bypass from DONE.
REQ-013 SHALL, in IDLE when in_valid=1 (clock edge E0), capture the operand, clear the 28-bit internal BCD scratch and the iteration counter, and move to SHIFT.
REQ-014 SHALL, in each SHIFT cycle, add 3 to every scratch digit >= 5, then shift {scratch, operand} left by 1 bit.
REQ-015 SHALL remain in SHIFT for exactly 20 cycles and enter DONE at edge E20, giving out_valid=1 from E20 (latency 20 cycles).
REQ-016 SHALL, on entering DONE, register bcd as the low six scratch digits when the 7-digit value is <= 999999, with overflow=0.
REQ-017 SHALL otherwise register bcd=0x999999 and overflow=1.
REQ-018 SHALL hold out_valid, bcd, overflow and negative stable in DONE until out_ready=1.
REQ-019 SHALL return to IDLE on the edge where out_ready=1 in DONE.
REQ-020 SHALL keep bcd, overflow and negative at their last registered values outside DONE, updating them only on DONE entry.
REQ-021 SHALL ignore in_valid while in SHIFT or DONE, so that in_data is not sampled.
REQ-022 SHALL treat out_ready outside DONE as having no effect.

Reset
REQ-023 SHALL, while rst_n=0, immediately force state=IDLE, out_valid=0, bcd=0, overflow=0, negative=0, counter=0 and scratch=0, regardless of the current state.
REQ-024 SHALL discard any conversion in flight at reset without producing an output.
REQ-025 SHALL have in_ready=1 in the first cycle after rst_n deasserts.

Configuration
REQ-026 SHALL, with NEG_DISPLAY_EN defined, interpret in_data as two's complement: if in_data[19]=1, negative=1 and the 20-bit negation is converted (-524288 yields 524288); otherwise negative=0.
REQ-027 SHALL, without NEG_DISPLAY_EN, treat in_data as unsigned, tie negative to 0 and exclude the negation logic.

Structure
REQ-028 SHALL take DATA_W=20, BCD_DIGITS=6, SCRATCH_DIGITS=7, ITERATIONS=20 and the state enum type from the shared package result_bcd_pkg.
REQ-029 SHALL instantiate the combinational sub-module bcd_add3 (4-bit in, 4-bit out, adds 3 when the input is >= 5) once per scratch digit.

Verification
REQ-030 SHALL test: in_data=491520 (15<<15), out_ready=1 -> out_valid high exactly 20 cycles after acceptance, bcd=0x491520, overflow=0.
REQ-031 SHALL test: in_data=0 -> bcd=0x000000, overflow=0, negative=0.
REQ-032 SHALL test: in_data=1000000 (0xF4240) -> bcd=0x999999, overflow=1.
REQ-033 SHALL test: in_data=0xFFFFD (3-6) with NEG_DISPLAY_EN -> negative=1, bcd=0x000003; without the macro -> overflow=1, negative=0.
REQ-034 SHALL test: result 12 with out_ready=0 for 5 cycles and in_valid held high -> outputs stable, in_ready=0, second operand accepted only after the out_ready handshake.
REQ-035 SHALL test: rst_n pulsed low at iteration 10 -> out_valid never rises for that operand, all outputs 0, in_ready=1 after release.
